// File: rtl/spi_burst_ram.sv
// rtl/spi_burst_ram.sv - command-decoded RAM with auto-increment writes and handshaked burst reads
module spi_burst_ram #(
  parameter int WORD_W    = 8,
  parameter int MEM_DEPTH = 2**WORD_W,  // must equal 2**WORD_W so pointers wrap naturally
  parameter int AUTO_INC  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx_valid,
  input  logic [WORD_W+1:0] i_din,
  input  logic              i_tx_ready,
  output logic [WORD_W-1:0] o_dout,
  output logic              o_tx_valid,
  output logic              o_busy,
  output logic              o_cmd_err
);

  localparam logic [1:0] CMD_SET_WADDR = 2'b00;
  localparam logic [1:0] CMD_WRITE     = 2'b01;
  localparam logic [1:0] CMD_SET_RADDR = 2'b10;
  localparam logic [1:0] CMD_READ      = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  logic [WORD_W-1:0] r_mem [MEM_DEPTH];

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD_W-1:0] r_wr_ptr;
  logic [WORD_W-1:0] w_wr_ptr_nxt;
  logic [WORD_W-1:0] r_rd_ptr;
  logic [WORD_W-1:0] w_rd_ptr_nxt;
  logic [WORD_W-1:0] w_rd_ptr_inc;
  logic [WORD_W-1:0] r_cnt;
  logic [WORD_W-1:0] w_cnt_nxt;
  logic              r_cmd_err;
  logic              w_cmd_err_nxt;
  logic [WORD_W-1:0] r_dout;

  logic [1:0]        w_cmd;
  logic [WORD_W-1:0] w_payload;
  logic              w_mem_we;
  logic              w_load;
  logic [WORD_W-1:0] w_load_addr;

  assign w_cmd        = i_din[WORD_W+1:WORD_W];
  assign w_payload    = i_din[WORD_W-1:0];
  assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

  // Command decode and burst sequencing; all next-state values default to hold
  always_comb begin
    w_state_nxt   = r_state;
    w_wr_ptr_nxt  = r_wr_ptr;
    w_rd_ptr_nxt  = r_rd_ptr;
    w_cnt_nxt     = r_cnt;
    w_cmd_err_nxt = r_cmd_err;
    w_mem_we      = 1'b0;
    w_load        = 1'b0;
    w_load_addr   = r_rd_ptr;

    if (i_rx_valid) begin
      case (w_cmd)
        CMD_SET_WADDR: w_wr_ptr_nxt = w_payload;
        CMD_WRITE: begin
          w_mem_we = 1'b1;
          if (AUTO_INC != 0) begin
            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
          end
        end
        CMD_SET_RADDR: begin
          if (r_state == S_IDLE) begin
            w_rd_ptr_nxt = w_payload;
          end else begin
            w_cmd_err_nxt = 1'b1;
          end
        end
        CMD_READ: begin
          if (r_state == S_IDLE) begin
            w_load      = 1'b1;
            w_load_addr = r_rd_ptr;
            w_cnt_nxt   = w_payload;
            w_state_nxt = S_SEND;
          end else begin
            // A READ on the edge that ends a burst still sees SEND and is rejected
            w_cmd_err_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Read-type commands never change rd_ptr while in SEND, so no conflict here
    if (r_state == S_SEND && i_tx_ready) begin
      w_rd_ptr_nxt = w_rd_ptr_inc;
      if (r_cnt != '0) begin
        w_load      = 1'b1;
        w_load_addr = w_rd_ptr_inc;
        w_cnt_nxt   = r_cnt - 1'b1;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  // Control registers; reset aborts any burst immediately
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_cmd_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cmd_err <= w_cmd_err_nxt;
    end
  end

  // Output data register; samples the array before this edge's write lands (read-before-write)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dout <= '0;
    end else if (w_load) begin
      r_dout <= r_mem[w_load_addr];
    end
  end

  // Storage array, deliberately not reset
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr] <= w_payload;
    end
  end

  assign o_dout     = r_dout;
  assign o_tx_valid = (r_state == S_SEND);
  assign o_busy     = (r_state == S_SEND);
  assign o_cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_spi_burst_ram.sv
// tb/tb_spi_burst_ram.sv - scoreboard bench for spi_burst_ram
module tb_spi_burst_ram;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [9:0] din;
  logic       tx_ready;
  logic [7:0] dout;
  logic       tx_valid;
  logic       busy;
  logic       cmd_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb_q [$];
  logic [7:0] m_mem [256];
  logic [7:0] m_wp;
  logic [7:0] m_rp;

  bit         hold_pending;
  logic [7:0] hold_val;

  spi_burst_ram #(.WORD_W(8), .MEM_DEPTH(256), .AUTO_INC(1)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx_valid (rx_valid),
    .i_din      (din),
    .i_tx_ready (tx_ready),
    .o_dout     (dout),
    .o_tx_valid (tx_valid),
    .o_busy     (busy),
    .o_cmd_err  (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send(input logic [1:0] cmd, input logic [7:0] pay);
    rx_valid = 1'b1;
    din      = {cmd, pay};
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    din      = 10'($urandom);
  endtask

  task automatic cmd_waddr(input logic [7:0] a);
    send(2'b00, a);
    m_wp = a;
  endtask

  task automatic cmd_write(input logic [7:0] d);
    send(2'b01, d);
    m_mem[m_wp] = d;
    m_wp = m_wp + 8'd1;
  endtask

  task automatic cmd_raddr(input logic [7:0] a);
    send(2'b10, a);
    m_rp = a;
  endtask

  // mode 0: tx_ready held high; mode 1: tx_ready toggles every cycle
  task automatic read_burst(input logic [7:0] len, input int mode, input int exp_cycles);
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      sb_q.push_back(m_mem[8'(int'(m_rp) + i)]);
    end
    m_rp = 8'(int'(m_rp) + int'(len) + 1);
    tx_ready = (mode == 0);
    send(2'b11, len);
    n = 0;
    while (sb_q.size() != 0 && n < 600) begin
      @(posedge clk);
      #1;
      if (mode == 1) tx_ready = ~tx_ready;
      n++;
    end
    chk("drain_left", 8'(sb_q.size()), 8'd0);
    if (exp_cycles > 0) chk("burst_cycles", 8'(n), 8'(exp_cycles));
    chk("post_busy", {7'd0, busy}, 8'd0);
    chk("post_valid", {7'd0, tx_valid}, 8'd0);
    tx_ready = 1'b0;
  endtask

  // Output monitor: pops on each accepted word and checks stability while stalled
  initial begin
    hold_pending = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !tx_valid) begin
        hold_pending = 0;
      end else begin
        if (hold_pending) chk("hold", dout, hold_val);
        if (tx_ready) begin
          if (sb_q.size() == 0) chk("extra_word", 8'd1, 8'd0);
          else chk("dout", dout, sb_q.pop_front());
          hold_pending = 0;
        end else begin
          hold_pending = 1;
          hold_val     = dout;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    din      = '0;
    tx_ready = 1'b0;
    m_wp     = '0;
    m_rp     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 8'd0);
    chk("rst_valid", {7'd0, tx_valid}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_err", {7'd0, cmd_err}, 8'd0);
    rst_n = 1'b1;

    // stale din with rx_valid low must not decode
    din = {2'b11, 8'h05};
    repeat (3) @(posedge clk);
    #1;
    chk("stale_busy", {7'd0, busy}, 8'd0);

    // 1: write with auto-increment
    cmd_waddr(8'h10);
    cmd_write(8'hA5);
    cmd_write(8'h5A);
    cmd_raddr(8'h10);
    read_burst(8'd1, 0, 2);

    // 2: back-to-back burst
    cmd_waddr(8'h20);
    for (int i = 1; i <= 4; i++) cmd_write(8'(i));
    cmd_raddr(8'h20);
    read_burst(8'd3, 0, 4);

    // 3: same burst with stalls
    cmd_raddr(8'h20);
    read_burst(8'd3, 1, 0);

    // 4: wrap on write and read pointers, then sequential continuation
    cmd_waddr(8'hFF);
    cmd_write(8'hC3);
    cmd_write(8'h3C);
    cmd_write(8'h7E);
    cmd_raddr(8'hFF);
    read_burst(8'd1, 0, 2);
    read_burst(8'd0, 0, 1);

    // 5: illegal commands during burst and read/write collision
    cmd_waddr(8'h40);
    cmd_write(8'h11);
    cmd_write(8'h22);
    cmd_write(8'h33);
    cmd_raddr(8'h40);
    chk("err_pre", {7'd0, cmd_err}, 8'd0);
    sb_q.push_back(8'h11);
    sb_q.push_back(8'h22);
    sb_q.push_back(8'h33);
    tx_ready = 1'b0;
    send(2'b11, 8'd2);
    m_rp = 8'h43;
    send(2'b11, 8'd5);
    chk("err_read", {7'd0, cmd_err}, 8'd1);
    chk("busy_mid", {7'd0, busy}, 8'd1);
    send(2'b10, 8'h80);
    cmd_waddr(8'h41);
    tx_ready = 1'b1;
    cmd_write(8'h99);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("coll_left", 8'(sb_q.size()), 8'd0);
    chk("coll_busy", {7'd0, busy}, 8'd0);
    chk("err_sticky", {7'd0, cmd_err}, 8'd1);
    tx_ready = 1'b0;
    read_burst(8'd0, 0, 1);
    cmd_raddr(8'h41);
    read_burst(8'd0, 0, 1);

    // 6: reset mid-burst
    cmd_raddr(8'h20);
    tx_ready = 1'b0;
    send(2'b11, 8'd5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {7'd0, tx_valid}, 8'd0);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_dout", dout, 8'd0);
    chk("abort_err", {7'd0, cmd_err}, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_wp  = '0;
    m_rp  = '0;
    cmd_raddr(8'h20);
    read_burst(8'd1, 0, 2);
    cmd_write(8'hEE);
    cmd_raddr(8'h00);
    read_burst(8'd0, 0, 1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
